// File: rtl/aes_stream_host_if.sv
// Handshake bundle between the upstream master, aes_stream_host and the accelerator FIFO ports.
// The slave modport is the host's view; master is the view of everything around it.
interface aes_stream_host_if #(
  parameter int unsigned DATA_W = 128
);
  logic              key_valid;
  logic              key_ready;
  logic [DATA_W-1:0] key_data;

  logic              blk_valid;
  logic              blk_ready;
  logic [DATA_W-1:0] blk_data;
  logic              blk_last;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  logic [DATA_W-1:0] acc_in_dout;
  logic              acc_in_empty_n;
  logic              acc_in_read;

  logic [DATA_W-1:0] acc_out_din;
  logic              acc_out_write;
  logic              acc_out_full_n;

  logic              busy;
  logic              err;

  modport slave (
    input  key_valid, key_data,
    output key_ready,
    input  blk_valid, blk_data, blk_last,
    output blk_ready,
    output res_valid, res_data,
    input  res_ready,
    output acc_in_dout, acc_in_empty_n,
    input  acc_in_read,
    input  acc_out_din, acc_out_write,
    output acc_out_full_n,
    output busy, err
  );

  modport master (
    output key_valid, key_data,
    input  key_ready,
    output blk_valid, blk_data, blk_last,
    input  blk_ready,
    input  res_valid, res_data,
    output res_ready,
    input  acc_in_dout, acc_in_empty_n,
    output acc_in_read,
    output acc_out_din, acc_out_write,
    input  acc_out_full_n,
    input  busy, err
  );
endinterface

// File: rtl/aes_stream_host.sv
// Session host for a streaming AES accelerator: sends key then plaintext, collects results in order.
// Optional macro AES_HOST_BSWAP_EN byte-reverses words on the accelerator side of the block.
module aes_stream_host #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned MAX_OUT = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  aes_stream_host_if.slave bus
);
  localparam int unsigned PtrW = $clog2(MAX_OUT);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUT);

  typedef enum logic [1:0] {StIdle, StKey, StText, StDrain} state_e;

  function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] w);
`ifdef AES_HOST_BSWAP_EN
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DATA_W / 8); i++) begin
      r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
    end
    return r;
`else
    return w;
`endif
  endfunction

  state_e            state_q, state_d;
  logic              key_ready_q, key_ready_d;
  logic              empty_n_q, empty_n_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              slot_full_q, slot_full_d;
  logic              slot_last_q, slot_last_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              full_n_q, full_n_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [MAX_OUT];

  logic key_fire, rd_fire, text_rd, blk_ready, blk_fire;
  logic res_valid, pop, wr_ok, wr_bad;

  always_comb begin
    key_fire  = bus.key_valid & key_ready_q;
    rd_fire   = bus.acc_in_read & empty_n_q;
    text_rd   = rd_fire & (state_q == StText);
    // A slot holding the last block must not be refilled as it drains.
    blk_ready = (state_q == StText) & (~slot_full_q | (rd_fire & ~slot_last_q));
    blk_fire  = bus.blk_valid & blk_ready;
    res_valid = (cnt_q != '0);
    pop       = res_valid & bus.res_ready;
    // Equal occupancy and outstanding means no result is owed: the write is unsolicited.
    wr_ok     = bus.acc_out_write & full_n_q & (cnt_q != outstanding_q);
    wr_bad    = bus.acc_out_write & ~wr_ok;
  end

  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    slot_full_d = slot_full_q;
    slot_last_d = slot_last_q;

    unique case (state_q)
      StIdle: begin
        if (key_fire) begin
          dout_d  = bswap(bus.key_data);
          state_d = StKey;
        end
      end
      StKey: begin
        if (rd_fire) state_d = StText;
      end
      StText: begin
        if (text_rd) begin
          slot_full_d = 1'b0;
          if (slot_last_q) state_d = StDrain;
        end
        if (blk_fire) begin
          slot_full_d = 1'b1;
          slot_last_d = bus.blk_last;
          dout_d      = bswap(bus.blk_data);
        end
      end
      StDrain: begin
        if (outstanding_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    unique case ({text_rd, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    unique case ({wr_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    full_n_d = (cnt_d != MaxCnt);

    empty_n_d = (state_d == StKey) |
                ((state_d == StText) & slot_full_d & (outstanding_d < MaxCnt));

    key_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    err_d       = err_q | wr_bad;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= StIdle;
      key_ready_q   <= 1'b0;
      empty_n_q     <= 1'b0;
      dout_q        <= '0;
      slot_full_q   <= 1'b0;
      slot_last_q   <= 1'b0;
      outstanding_q <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      full_n_q      <= 1'b0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      key_ready_q   <= key_ready_d;
      empty_n_q     <= empty_n_d;
      dout_q        <= dout_d;
      slot_full_q   <= slot_full_d;
      slot_last_q   <= slot_last_d;
      outstanding_q <= outstanding_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      full_n_q      <= full_n_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < int'(MAX_OUT); i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= bswap(bus.acc_out_din);
    end
  end

  assign bus.key_ready      = key_ready_q;
  assign bus.blk_ready      = blk_ready;
  assign bus.res_valid      = res_valid;
  assign bus.res_data       = mem_q[rd_ptr_q];
  assign bus.acc_in_dout    = dout_q;
  assign bus.acc_in_empty_n = empty_n_q;
  assign bus.acc_out_full_n = full_n_q;
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;

  // Offered accelerator word must hold until it is taken.
  a_dout_stable: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (empty_n_q && !bus.acc_in_read) |=> $stable(dout_q));

  a_outstanding_bound: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    outstanding_q <= MaxCnt);

  a_fifo_le_outstanding: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    cnt_q <= outstanding_q);

endmodule

// File: tb/tb_aes_stream_host.sv
// Directed self-checking bench for aes_stream_host, built with MAX_OUT=4.
module tb_aes_stream_host;
  localparam logic [127:0] Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_HOST_BSWAP_EN
  localparam logic [127:0] KeyX = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PtX  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CtX  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
`else
  localparam logic [127:0] KeyX = Key;
  localparam logic [127:0] PtX  = Pt;
  localparam logic [127:0] CtX  = Ct;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  aes_stream_host_if #(.DATA_W(128)) bus ();

  aes_stream_host #(
    .DATA_W (128),
    .MAX_OUT(4)
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (bus)
  );

  // Expected accelerator-side / FIFO-side image of a word.
  function automatic logic [127:0] xw(input logic [127:0] w);
`ifdef AES_HOST_BSWAP_EN
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = w[120-8*i +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] blkv(input int i);
    return {4{32'hb000_0000 + 32'(i)}};
  endfunction

  function automatic logic [127:0] rv(input int i);
    return {4{32'hc0de_0000 + 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_session(input string tg);
    bus.key_valid = 1'b1;
    bus.key_data  = Key;
    tick();
    bus.key_valid = 1'b0;
    #1;
    chk({tg, "_key_empty_n"}, bus.acc_in_empty_n, 1);
    chk({tg, "_key_dout"}, bus.acc_in_dout, KeyX);
    chk({tg, "_key_busy"}, bus.busy, 1);
    chk({tg, "_key_ready_low"}, bus.key_ready, 0);
    bus.acc_in_read = 1'b1;
    #1;
    chk({tg, "_key_blk_ready"}, bus.blk_ready, 0);
    tick();
    bus.acc_in_read = 1'b0;
    bus.blk_valid   = 1'b1;
    bus.blk_data    = Pt;
    bus.blk_last    = 1'b1;
    #1;
    chk({tg, "_text_empty_n"}, bus.acc_in_empty_n, 0);
    chk({tg, "_text_blk_ready"}, bus.blk_ready, 1);
    tick();
    bus.blk_valid = 1'b0;
    bus.blk_last  = 1'b0;
    #1;
    chk({tg, "_blk_empty_n"}, bus.acc_in_empty_n, 1);
    chk({tg, "_blk_dout"}, bus.acc_in_dout, PtX);
    bus.acc_in_read = 1'b1;
    #1;
    chk({tg, "_last_blk_ready"}, bus.blk_ready, 0);
    tick();
    bus.acc_in_read   = 1'b0;
    bus.acc_out_write = 1'b1;
    bus.acc_out_din   = Ct;
    #1;
    chk({tg, "_drain_empty_n"}, bus.acc_in_empty_n, 0);
    chk({tg, "_drain_busy"}, bus.busy, 1);
    chk({tg, "_drain_res_valid"}, bus.res_valid, 0);
    tick();
    bus.acc_out_write = 1'b0;
    #1;
    chk({tg, "_res_valid"}, bus.res_valid, 1);
    chk({tg, "_res_data"}, bus.res_data, CtX);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #1;
    chk({tg, "_pop_res_valid"}, bus.res_valid, 0);
    chk({tg, "_pop_busy"}, bus.busy, 1);
    tick();
    #1;
    chk({tg, "_idle_busy"}, bus.busy, 0);
    chk({tg, "_idle_key_ready"}, bus.key_ready, 1);
    chk({tg, "_idle_err"}, bus.err, 0);
  endtask

  task automatic chk_reset_outputs(input string tg);
    chk({tg, "_key_ready"}, bus.key_ready, 0);
    chk({tg, "_blk_ready"}, bus.blk_ready, 0);
    chk({tg, "_empty_n"}, bus.acc_in_empty_n, 0);
    chk({tg, "_res_valid"}, bus.res_valid, 0);
    chk({tg, "_busy"}, bus.busy, 0);
    chk({tg, "_err"}, bus.err, 0);
    chk({tg, "_full_n"}, bus.acc_out_full_n, 0);
  endtask

  initial begin
    int           nrd;
    int           nblk;
    logic         fire;
    logic [127:0] last_rd;

    bus.key_valid = 1'b0;  bus.key_data = '0;
    bus.blk_valid = 1'b0;  bus.blk_data = '0;  bus.blk_last = 1'b0;
    bus.res_ready = 1'b0;  bus.acc_in_read = 1'b0;
    bus.acc_out_write = 1'b0;  bus.acc_out_din = '0;

    // Power-on reset.
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    #18 rst_n = 1'b1;
    tick();
    chk("por_key_ready_first_edge", bus.key_ready, 1);
    chk("por_full_n", bus.acc_out_full_n, 1);
    #1;

    // Single-block session.
    run_session("s1");

    // Unsolicited result with nothing outstanding.
    bus.acc_out_write = 1'b1;
    bus.acc_out_din   = rv(99);
    tick();
    bus.acc_out_write = 1'b0;
    #1;
    chk("unsol_err", bus.err, 1);
    chk("unsol_res_valid", bus.res_valid, 0);
    tick();
    chk("unsol_err_sticky", bus.err, 1);
    chk("unsol_res_valid_later", bus.res_valid, 0);
    #1 rst_n = 1'b0;
    #1 chk("rst_clears_err", bus.err, 0);
    #3 rst_n = 1'b1;
    tick();
    #1;

    // Credit limit: 6 blocks, results withheld.
    bus.key_valid = 1'b1;
    bus.key_data  = Key;
    tick();
    bus.key_valid   = 1'b0;
    bus.acc_in_read = 1'b1;
    tick();
    bus.blk_valid = 1'b1;
    bus.blk_data  = blkv(0);
    bus.blk_last  = 1'b0;
    #1;
    nrd     = 0;
    nblk    = 0;
    last_rd = '0;
    for (int c = 0; c < 16; c++) begin
      if (bus.acc_in_empty_n && bus.acc_in_read) begin
        nrd++;
        last_rd = bus.acc_in_dout;
      end
      fire = bus.blk_valid && bus.blk_ready;
      tick();
      if (fire) begin
        nblk++;
        if (nblk < 6) begin
          bus.blk_data = blkv(nblk);
          bus.blk_last = (nblk == 5);
        end else begin
          bus.blk_valid = 1'b0;
        end
      end
      #1;
    end
    bus.acc_in_read = 1'b0;
    chk("credit_reads", 128'(nrd), 128'd4);
    chk("credit_blocks_accepted", 128'(nblk), 128'd5);
    chk("credit_last_read_word", last_rd, xw(blkv(3)));
    chk("credit_empty_n_low", bus.acc_in_empty_n, 0);
    chk("credit_blk_ready_low", bus.blk_ready, 0);

    bus.acc_out_write = 1'b1;
    bus.acc_out_din   = rv(0);
    tick();
    bus.acc_out_write = 1'b0;
    #1;
    chk("credit_r0_valid", bus.res_valid, 1);
    chk("credit_r0_data", bus.res_data, xw(rv(0)));
    chk("credit_still_blocked", bus.acc_in_empty_n, 0);

    // Pop R0 while R1 arrives: one credit returned.
    bus.res_ready     = 1'b1;
    bus.acc_out_write = 1'b1;
    bus.acc_out_din   = rv(1);
    tick();
    bus.res_ready     = 1'b0;
    bus.acc_out_write = 1'b0;
    #1;
    chk("credit_reopened", bus.acc_in_empty_n, 1);
    chk("credit_r1_data", bus.res_data, xw(rv(1)));

    // Pop and read together at outstanding = MAX_OUT-1.
    bus.res_ready   = 1'b1;
    bus.acc_in_read = 1'b1;
    #1;
    chk("same_cycle_blk_ready", bus.blk_ready, 1);
    tick();
    bus.res_ready   = 1'b0;
    bus.acc_in_read = 1'b0;
    bus.blk_valid   = 1'b0;
    bus.blk_last    = 1'b0;
    #1;
    chk("same_cycle_res_empty", bus.res_valid, 0);
    chk("same_cycle_empty_n", bus.acc_in_empty_n, 1);
    chk("same_cycle_dout", bus.acc_in_dout, xw(blkv(5)));
    bus.acc_in_read = 1'b1;
    tick();
    bus.acc_in_read = 1'b0;
    #1;
    chk("drain_empty_n", bus.acc_in_empty_n, 0);
    chk("drain_busy", bus.busy, 1);
    chk("drain_blk_ready", bus.blk_ready, 0);

    // Exactly four results are owed; a fifth write overflows.
    bus.acc_out_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.acc_out_din = rv(2 + i);
      tick();
    end
    bus.acc_out_din = rv(6);
    #1;
    chk("fifo_full_n", bus.acc_out_full_n, 0);
    chk("fifo_err_clean", bus.err, 0);
    chk("fifo_head", bus.res_data, xw(rv(2)));
    tick();
    bus.acc_out_write = 1'b0;
    #1;
    chk("overflow_err", bus.err, 1);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop_%0d_data", i), bus.res_data, xw(rv(2 + i)));
      tick();
      #1;
    end
    bus.res_ready = 1'b0;
    chk("pop_all_res_valid", bus.res_valid, 0);
    chk("pop_all_full_n", bus.acc_out_full_n, 1);
    chk("pop_all_busy", bus.busy, 1);
    tick();
    chk("credit_idle_busy", bus.busy, 0);
    #1;

    // Reset in TEXT with three blocks outstanding.
    bus.key_valid = 1'b1;
    bus.key_data  = Key;
    tick();
    bus.key_valid   = 1'b0;
    bus.acc_in_read = 1'b1;
    tick();
    bus.blk_valid = 1'b1;
    bus.blk_data  = blkv(7);
    bus.blk_last  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.blk_valid   = 1'b0;
    bus.acc_in_read = 1'b0;
    #1;
    chk("mid_busy", bus.busy, 1);
    chk("mid_empty_n", bus.acc_in_empty_n, 1);
    chk("mid_err_before_reset", bus.err, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_key_ready", bus.key_ready, 1);
    chk("post_rst_res_valid", bus.res_valid, 0);
    #1;
    run_session("s2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/aes_stream_host.md
AES_STREAM_HOST -- requirements
Module: aes_stream_host

Interface
REQ-001 Parameter DATA_W, default 128, width of key, plaintext and ciphertext words; only 128 is supported.
REQ-002 Parameter MAX_OUT, default 16, maximum number of in-flight blocks and depth of the result FIFO; power of two, 2..64.
REQ-003 ap_clk  in  1  single clock; all logic rising-edge.
REQ-004 ap_rst_n  in  1  asynchronous active-low reset.
REQ-005 key_valid / key_ready / key_data  in / out / in  1/1/128  session key from the upstream master; valid/ready handshake.
REQ-006 blk_valid / blk_ready / blk_data / blk_last  in / out / in / in  1/1/128/1  plaintext blocks; blk_last marks the final block of a session.
REQ-007 res_valid / res_ready / res_data  out / in / out  1/1/128  ciphertext blocks to the upstream master, in order.
REQ-008 acc_in_dout / acc_in_empty_n / acc_in_read  out / out / in  128/1/1  FIFO-style source feeding the accelerator input stream.
REQ-009 acc_out_din / acc_out_write / acc_out_full_n  in / in / out  128/1/1  FIFO-style sink for the accelerator output stream.
REQ-010 busy / err  out / out  1/1  session active; sticky protocol-error flag.

Function
REQ-011 FSM states SHALL be IDLE, KEY, TEXT and DRAIN.
REQ-012 IDLE: key_ready=1; on key handshake, register key_data and go to KEY.
REQ-013 KEY: acc_in_dout=key and acc_in_empty_n=1, held stable; on acc_in_read, go to TEXT.
REQ-014 TEXT: the block SHALL hold one registered plaintext slot.
- blk_ready=1 when the slot is empty, or when it is being read this cycle.
- acc_in_empty_n=1 while the slot is full and outstanding<MAX_OUT.
REQ-015 Each acc_in_read in TEXT SHALL:
- empty the slot;
- increment outstanding;
- if the word carried blk_last, go to DRAIN.
REQ-016 DRAIN: the block SHALL accept no key and no blocks; go to IDLE in the cycle after outstanding reaches 0.
REQ-017 acc_in_empty_n SHALL be registered, and dout SHALL NOT change while empty_n=1 and acc_in_read=0.
REQ-018 acc_out_write SHALL push acc_out_din into the result FIFO (depth MAX_OUT).
- acc_out_full_n = FIFO not full.
- res_valid = FIFO not empty.
- res_data = FIFO head, first-word-fall-through.
REQ-019 Each res handshake SHALL pop the FIFO and decrement outstanding.
- Simultaneous increment and decrement leave outstanding unchanged.
- Width is clog2(MAX_OUT)+1; the counter never wraps.
REQ-020 Latency:
- key_valid to acc_in_empty_n: 1 cycle.
- blk handshake to acc_in_empty_n: 1 cycle.
- acc_out_write to res_valid: 1 cycle.
REQ-021 acc_out_write with acc_out_full_n=0 SHALL drop the word and set err.
REQ-022 acc_out_write when FIFO occupancy equals outstanding (unsolicited result) SHALL drop the word and set err.
REQ-023 err SHALL clear only on reset.
REQ-024 busy SHALL be 1 in KEY, TEXT and DRAIN, and 0 in IDLE.
REQ-025 blk_valid in IDLE or DRAIN SHALL be stalled (blk_ready=0), never dropped.

Reset
REQ-026 Asserting ap_rst_n low SHALL asynchronously force:
- state=IDLE, outstanding=0, FIFO empty, slot empty;
- acc_in_empty_n=0, res_valid=0, busy=0, err=0;
- key_ready=0, blk_ready=0;
- acc_out_full_n=0 while asserted.
REQ-027 Reset mid-session SHALL discard in-flight data; after deassertion, key_ready=1 on the first clock edge.

Configuration
REQ-028 Macro AES_HOST_BSWAP_EN:
- When defined: acc_in_dout, and FIFO write data taken from acc_out_din, are byte-reversed (byte 0 <-> byte 15) relative to key_data/blk_data and res_data.
- When undefined: words pass unmodified.

Verification
REQ-029 Key 000102030405060708090a0b0c0d0e0f, one block 00112233445566778899aabbccddeeff with last; accelerator reads each word immediately -> acc_in carries the key then the block, busy=1, and the state returns to IDLE after one result handshake.
REQ-030 Same stimulus with AES_HOST_BSWAP_EN defined -> block appears as ffeeddccbbaa99887766554433221100 on acc_in_dout.
REQ-031 MAX_OUT=4, 6 blocks sent, results withheld, res_ready=0 -> exactly 4 acc_in_read in TEXT, then acc_in_empty_n=0 until one result is popped.
REQ-032 acc_out_write with no outstanding blocks -> word dropped, err=1, res_valid stays 0.
REQ-033 Reset asserted in TEXT with 3 outstanding -> all outputs at reset values within the same cycle; next session operates normally.
REQ-034 Result pop and acc_in_read in the same cycle at outstanding=MAX_OUT-1 -> outstanding remains MAX_OUT-1.
